uart_tx_fifo: RTL

- Byte FIFO between any byte producer (ROM sequencer, donut renderer, etc.) and the UART transmitter.
- Accepts bytes on a simple write strobe and buffers them.
- Drains bytes into the transmitter using its start/txe handshake, so producers never have to track serial timing.
- Reports fill level and a sticky overflow flag for bring-up.

---
 rtl/uart_tx_fifo.sv | 78 +++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between a producer and the UART transmitter.
//   Producers push with wr_en/wr_data; the FIFO drains into the transmitter
//   through its start/txe handshake, so producers never track serial timing.
// Ports:
//   clk, nrst        clock, async active-low reset
//   wr_en, wr_data   push strobe and byte (dropped while full)
//   full, empty      registered fill flags
//   level            number of stored bytes (0..DEPTH)
//   overflow         sticky: a push was attempted while full
//   clr_overflow     synchronous clear (a same-cycle overflow set wins)
//   tx_txe           transmitter buffer-empty flag
//   tx_start         start strobe to the transmitter (combinational)
//   tx_data          head of queue, valid whenever empty is low
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_overflow,
  input  logic                       tx_txe,
  output logic                       tx_start,
  output logic [WIDTH-1:0]           tx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             holdoff;
  logic             push, pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  // holdoff masks the cycle where the transmitter has taken the byte but
  // has not yet dropped txe; without it one transmission would pop twice.
  assign tx_start = !empty && tx_txe && !holdoff;
  assign tx_data  = mem[rd_ptr];

  // Both decisions use registered level, so a push into an empty FIFO
  // cannot pop in the same cycle and a push while full is always rejected.
  assign push = wr_en && !full;
  assign pop  = tx_start;

  // Storage is not reset; rd/wr pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      holdoff  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      holdoff <= pop;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule
